// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: access size codes and FSM states.
package mem_access_unit_pkg;

    localparam int unsigned XLEN = 32;

    // Access size codes carried on req_size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // IDLE accepts requests; RMW_WR writes back a merged sub-word store
    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_e;

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Lane steering for the memory access unit (purely combinational).
//   size_i     : access size code
//   unsigned_i : zero-extend loads when 1, sign-extend when 0
//   offset_i   : byte offset within the word (addr[1:0])
//   rd_word_i  : full word read from memory
//   wdata_i    : right-aligned store data
//   load_o     : selected lane, extended to 32 bits (word passes through)
//   merge_o    : rd_word_i with the target lane(s) replaced by store data
module lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    input  logic [1:0]      offset_i,
    input  logic [XLEN-1:0] rd_word_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] load_o,
    output logic [XLEN-1:0] merge_o
);

    logic [4:0]      byte_shamt;
    logic [4:0]      half_shamt;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] ins;

    // Little-endian lanes: byte k at bits [8k+7:8k], half selected by offset[1]
    assign byte_shamt = {offset_i, 3'b000};
    assign half_shamt = {offset_i[1], 4'b0000};
    assign lane_b     = 8'(rd_word_i >> byte_shamt);
    assign lane_h     = 16'(rd_word_i >> half_shamt);

    // Load extraction and store merge share one mask/insert pair
    always_comb begin
        load_o = rd_word_i;
        mask   = '1;
        ins    = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_o = unsigned_i ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
                mask   = 32'h0000_00FF << byte_shamt;
                ins    = 32'(wdata_i[7:0]) << byte_shamt;
            end
            SZ_HALF: begin
                load_o = unsigned_i ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
                mask   = 32'h0000_FFFF << half_shamt;
                ins    = 32'(wdata_i[15:0]) << half_shamt;
            end
            default: ;
        endcase
        merge_o = (rd_word_i & ~mask) | (ins & mask);
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of a word-wide data memory.
// Sub-word stores are done as read-modify-write over two cycles.
//   clk, rst            : clock, synchronous active-high reset
//   req_*               : load/store request from the MEM stage
//   mem_rd              : combinational read data from memory
//   mem_add/wd/mw/mre   : memory address, write data, write and read enables
//   stall               : upstream must hold its request next cycle
//   load_data/valid     : registered load result and its one-cycle pulse
//   acc_err             : registered one-cycle pulse for a rejected request
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] mem_rd,
    output logic [31:0] mem_add,
    output logic [31:0] mem_wd,
    output logic        mem_mw,
    output logic        mem_mre,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        acc_err
);

    state_e      state_q;
    logic [31:0] merge_q;
    logic [31:0] addr_q;
    logic [31:0] load_data_q;
    logic        load_valid_q;
    logic        acc_err_q;

    logic        align_ok;
    logic        range_ok;
    logic        req_ok;
    logic        in_idle;
    logic        do_load;
    logic        do_wstore;
    logic        do_sstore;
    logic        do_reject;
    logic        do_rmw;
    logic [31:0] align_load;
    logic [31:0] align_merge;

    // Alignment per size; reserved size never aligns
    always_comb begin
        align_ok = 1'b0;
        case (req_size)
            SZ_BYTE: align_ok = 1'b1;
            SZ_HALF: align_ok = ~req_addr[0];
            SZ_WORD: align_ok = (req_addr[1:0] == 2'b00);
            default: align_ok = 1'b0;
        endcase
    end

    assign range_ok = ({2'b00, req_addr[31:2]} < 32'(MEM_WORDS));
    assign req_ok   = align_ok & range_ok;
    assign in_idle  = (state_q == IDLE);

    // Reset masks every strobe, including an in-flight RMW write
    assign do_load   = ~rst & in_idle & req_valid & req_ok & ~req_we;
    assign do_wstore = ~rst & in_idle & req_valid & req_ok & req_we & (req_size == SZ_WORD);
    assign do_sstore = ~rst & in_idle & req_valid & req_ok & req_we & (req_size != SZ_WORD);
    assign do_reject = ~rst & in_idle & req_valid & ~req_ok;
    assign do_rmw    = ~rst & (state_q == RMW_WR);

    lane_align u_lane_align (
        .size_i     (req_size),
        .unsigned_i (req_unsigned),
        .offset_i   (req_addr[1:0]),
        .rd_word_i  (mem_rd),
        .wdata_i    (req_wdata),
        .load_o     (align_load),
        .merge_o    (align_merge)
    );

    // Memory-side strobes are combinational so the access lands in the same cycle
    always_comb begin
        mem_mre = do_load | do_sstore;
        mem_mw  = do_wstore | do_rmw;
        stall   = do_sstore;
        mem_add = 32'h0;
        mem_wd  = 32'h0;
        if (do_rmw) begin
            mem_add = addr_q;
            mem_wd  = merge_q;
        end else if (do_load | do_sstore | do_wstore) begin
            mem_add = req_addr;
            mem_wd  = do_wstore ? req_wdata : 32'h0;
        end
    end

    // FSM and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            merge_q      <= 32'h0;
            addr_q       <= 32'h0;
            load_data_q  <= 32'h0;
            load_valid_q <= 1'b0;
            acc_err_q    <= 1'b0;
        end else begin
            load_valid_q <= do_load;
            acc_err_q    <= do_reject;
            if (do_load) begin
                load_data_q <= align_load;
            end
            case (state_q)
                IDLE: begin
                    if (do_sstore) begin
                        merge_q <= align_merge;
                        addr_q  <= req_addr;
                        state_q <= RMW_WR;
                    end
                end
                RMW_WR:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign acc_err    = acc_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a word-array reference model.
module tb_mem_access_unit;

    localparam int unsigned WORDS = 128;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] mem_rd;
    logic [31:0] mem_add;
    logic [31:0] mem_wd;
    logic        mem_mw;
    logic        mem_mre;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        acc_err;

    logic [31:0] mem     [WORDS];
    logic [31:0] ref_mem [WORDS];
    logic [31:0] last_load;
    int          n_checks;
    int          n_fail;

    mem_access_unit #(.MEM_WORDS(WORDS)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .mem_rd       (mem_rd),
        .mem_add      (mem_add),
        .mem_wd       (mem_wd),
        .mem_mw       (mem_mw),
        .mem_mre      (mem_mre),
        .stall        (stall),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .acc_err      (acc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, write on negedge
    assign mem_rd = ({2'b00, mem_add[31:2]} < 32'(WORDS)) ? mem[mem_add[8:2]] : 32'h0;
    always @(negedge clk) begin
        if (mem_mw && ({2'b00, mem_add[31:2]} < 32'(WORDS)))
            mem[mem_add[8:2]] <= mem_wd;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference rules, written per byte rather than with masks
    function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'b11) return 1'b1;
        if (size == 2'b01 && addr[0]) return 1'b1;
        if (size == 2'b10 && addr[1:0] != 2'b00) return 1'b1;
        return (addr / 4) >= WORDS;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] size,
                                               input int off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = w[16*(off/2) +: 16];
        if (size == 2'b00) return uns ? 32'(b) : 32'($signed(b));
        if (size == 2'b01) return uns ? 32'(h) : 32'($signed(h));
        return w;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] size,
                                                input int off, input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (size == 2'b00 && i == off) r[8*i +: 8] = wd[7:0];
            if (size == 2'b01 && i / 2 == off / 2) r[8*i +: 8] = wd[8*(i - 2*(off/2)) +: 8];
            if (size == 2'b10) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    // One request from IDLE, called at posedge+1; returns at posedge+1
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        logic        err;
        int          idx;
        int          off;
        logic [31:0] merged;
        err = model_err(size, addr);
        idx = int'(addr[8:2]);
        off = int'(addr[1:0]);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        #2;
        if (err) begin
            check("rej_mre", 32'(mem_mre), 32'd0);
            check("rej_mw", 32'(mem_mw), 32'd0);
            check("rej_stall", 32'(stall), 32'd0);
        end else if (!we) begin
            check("ld_mre", 32'(mem_mre), 32'd1);
            check("ld_mw", 32'(mem_mw), 32'd0);
            check("ld_stall", 32'(stall), 32'd0);
            check("ld_add", mem_add, addr);
        end else if (size == 2'b10) begin
            check("sw_mw", 32'(mem_mw), 32'd1);
            check("sw_add", mem_add, addr);
            check("sw_wd", mem_wd, wd);
            check("sw_stall", 32'(stall), 32'd0);
        end else begin
            check("ss_stall", 32'(stall), 32'd1);
            check("ss_mre", 32'(mem_mre), 32'd1);
            check("ss_mw", 32'(mem_mw), 32'd0);
            check("ss_add", mem_add, addr);
        end
        @(posedge clk); #1;
        if (!err && !we) last_load = model_load(ref_mem[idx], size, off, uns);
        check("acc_err", 32'(acc_err), 32'(err));
        check("load_valid", 32'(load_valid), 32'(!err && !we));
        check("load_data", load_data, last_load);
        if (!err && we && size == 2'b10) begin
            ref_mem[idx] = wd;
            check("sw_memword", mem[idx], ref_mem[idx]);
        end
        if (!err && we && size != 2'b10) begin
            merged = model_store(ref_mem[idx], size, off, wd);
            #2;
            check("rmw_mw", 32'(mem_mw), 32'd1);
            check("rmw_wd", mem_wd, merged);
            check("rmw_add", mem_add, addr);
            check("rmw_stall", 32'(stall), 32'd0);
            check("rmw_mre", 32'(mem_mre), 32'd0);
            @(posedge clk); #1;
            ref_mem[idx] = merged;
            check("rmw_memword", mem[idx], ref_mem[idx]);
            check("rmw_lv", 32'(load_valid), 32'd0);
            check("rmw_err", 32'(acc_err), 32'd0);
        end
    endtask

    task automatic idle_cycle();
        req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        #2;
        check("idle_strobes", {29'h0, mem_mw, mem_mre, stall}, 32'h0);
        check("idle_add", mem_add, 32'h0);
        check("idle_wd", mem_wd, 32'h0);
        @(posedge clk); #1;
        check("idle_pulses", {30'h0, load_valid, acc_err}, 32'h0);
        check("idle_hold", load_data, last_load);
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
        req_addr = 32'h4; req_wdata = $urandom;
        #2;
        check("rst_strobes", {30'h0, mem_mw, mem_mre}, 32'h0);
        check("rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        last_load = 32'h0;
        check("rst_load_data", load_data, 32'h0);
        check("rst_pulses", {30'h0, load_valid, acc_err}, 32'h0);
    endtask

    initial begin
        logic [31:0] addr;
        logic [31:0] old;
        n_checks = 0; n_fail = 0; last_load = 32'h0;
        for (int i = 0; i < int'(WORDS); i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        @(posedge clk); #1;
        do_reset();

        // Word store then load back
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("ld_deadbeef", load_data, 32'hDEADBEEF);

        // Byte store read-modify-write
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
        do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA);
        check("rmw_11aa3344", mem[4], 32'h11AA3344);

        // Byte load sign/zero extension from the top lane
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF0000);
        do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        check("lb_signed", load_data, 32'hFFFFFF80);
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        check("lb_unsigned", load_data, 32'h00000080);

        // Half load and misaligned half
        do_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h80011234);
        do_req(1'b0, 2'b01, 1'b0, 32'h2, 32'h0);
        check("lh_signed", load_data, 32'hFFFF8001);
        do_req(1'b0, 2'b01, 1'b0, 32'h1, 32'h0);

        // Out-of-range word accesses
        do_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
        do_req(1'b1, 2'b10, 1'b0, 32'h200, 32'h12345678);
        do_req(1'b0, 2'b11, 1'b0, 32'h8, 32'h0);

        // Reset during the write-back cycle aborts the store
        addr = 32'h26;
        old = ref_mem[9];
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_addr = addr; req_wdata = 32'h0000BEEF;
        #2;
        check("abort_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        check("abort_mw", 32'(mem_mw), 32'd0);
        check("abort_stall2", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0; last_load = 32'h0;
        check("abort_memword", mem[9], old);
        check("abort_load_data", load_data, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
        check("abort_readback", load_data, old);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int sel;
            sel = int'($urandom_range(0, 19));
            if (sel == 0) begin
                idle_cycle();
            end else begin
                if (sel == 1)
                    addr = {$urandom_range(32'h0000_0080, 32'h3FFF_FFFF), 2'($urandom)};
                else
                    addr = {23'h0, 7'($urandom), 2'($urandom)};
                do_req(1'($urandom), ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                       1'($urandom), addr, $urandom);
            end
        end

        for (int i = 0; i < int'(WORDS); i += 16)
            check("final_mem", mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: MEM_WORDS, default 128, number of 32-bit words in the downstream data memory.
REQ-002 Port: clk  in  1  single clock; all state updates on posedge; memory writes on the following negedge.
REQ-003 Port: rst  in  1  reset, synchronous, active-high.
REQ-004 Port: req_valid  in  1  the MEM stage holds a load or store this cycle.
REQ-005 Port: req_we  in  1  1 = store, 0 = load.
REQ-006 Port: req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-007 Port: req_unsigned  in  1  zero-extend loads; sign-extend when 0.
REQ-008 Port: req_addr  in  32  byte address.
REQ-009 Port: req_wdata  in  32  store data, right-aligned.
REQ-010 Port: mem_rd  in  32  combinational read data from the memory.
REQ-011 Port: mem_add  out  32  byte address to the memory.
REQ-012 Port: mem_wd  out  32  full-word write data to the memory.
REQ-013 Port: mem_mw  out  1  memory write enable.
REQ-014 Port: mem_mre  out  1  memory read enable.
REQ-015 Port: stall  out  1  upstream must hold its request unchanged next cycle.
REQ-016 Port: load_data  out  32  registered, aligned and extended load result.
REQ-017 Port: load_valid  out  1  one-cycle pulse: load_data holds a new result.
REQ-018 Port: acc_err  out  1  one-cycle registered pulse: the request was rejected.

Function
REQ-019 The FSM SHALL have two states: IDLE and RMW_WR.
REQ-020 Byte lane k = addr[1:0] SHALL select bits [8k+7:8k] (little-endian). Half lane = addr[1].
REQ-021 A request SHALL be rejected if size = 11, if a half has addr[0] = 1, if a word has addr[1:0] != 0, or if addr[31:2] >= MEM_WORDS.
REQ-022 On a rejected request: no mem_mre, no mem_mw, no stall, and acc_err = 1 in the next cycle.
REQ-023 Word store in IDLE: mem_mw = 1, mem_wd = req_wdata, mem_add = req_addr in the same cycle. No stall. State stays IDLE.
REQ-024 Sub-word store in IDLE: mem_mre = 1, stall = 1.
  - At the posedge, store mem_rd with the target lane(s) replaced by req_wdata[7:0] or [15:0] into merge_q.
  - Store the address into addr_q.
  - Go to RMW_WR.
REQ-025 In RMW_WR: mem_mw = 1, mem_wd = merge_q, mem_add = addr_q, stall = 0.
  - Request inputs are ignored; the held request is consumed at the end of this cycle.
  - Next state is IDLE.
REQ-026 Load in IDLE: mem_mre = 1, mem_add = req_addr, no stall.
  - At the posedge, load_data = the selected lane, sign- or zero-extended per req_unsigned.
  - load_valid = 1 in the next cycle.
  - Word loads pass through unchanged.
REQ-027 When not accessing: mem_mw = 0, mem_mre = 0, mem_add = 0, mem_wd = 0.
REQ-028 load_data SHALL hold its value until the next valid load. load_valid and acc_err SHALL be 0 otherwise.
REQ-029 Total store latency: word 1 cycle, sub-word 2 cycles. Load result latency: 1 cycle.

Reset
REQ-030 When rst = 1 at a posedge, the block SHALL go to IDLE and clear load_data, load_valid, acc_err, merge_q and addr_q to 0.
REQ-031 While rst = 1, mem_mw and mem_mre SHALL be forced to 0 and stall = 0.
  - Reset asserted in RMW_WR aborts the pending write; memory is not modified.

Structure
REQ-032 A shared package SHALL hold the size codes (SZ_BYTE, SZ_HALF, SZ_WORD) and the state encoding; MEM_WORDS stays a module parameter.
REQ-033 One combinational sub-module, lane_align, SHALL do load extraction/extension and store merge. The FSM and registers stay in mem_access_unit.

Verification
REQ-034 Word store of 0xDEADBEEF at address 0x10 -> mem_mw = 1 that cycle with mem_add = 0x10, stall = 0; a later word load from 0x10 gives load_data = 0xDEADBEEF.
REQ-035 Memory word 0x11223344, byte store of 0xAA at 0x12 -> stall = 1 for one cycle, then mem_mw = 1 with mem_wd = 0x11AA3344.
REQ-036 Byte load from 0x13 with the word 0x80FF0000: req_unsigned = 0 gives 0xFFFFFF80; req_unsigned = 1 gives 0x00000080.
REQ-037 Half load from 0x02 of 0x8001xxxx -> 0xFFFF8001. Half load from 0x01 -> acc_err pulse, mem_mre = 0, load_valid = 0.
REQ-038 Word access at 0x200 (word 128, MEM_WORDS = 128) -> acc_err pulse, no memory strobe.
REQ-039 Sub-word store with rst asserted in RMW_WR -> mem_mw stays 0, state is IDLE, and memory keeps its old word.
